// File: rtl/tx_pkt_gate.sv
// Packet gate between the FIFO_I read port and the radio transmit path.
// Validates the length header, waits for the full body to be resident, then streams header and body words.
module tx_pkt_gate #(
    parameter int LEN_MAX      = 255,
    parameter int GAP_CYCLES   = 64,
    parameter int HINT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [17:0] fifo_count,
    output logic        fifo_read,
    input  logic        fifo_hint,
    input  logic [15:0] fifo_data,
    output logic [15:0] pkt_word,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_first,
    output logic        pkt_last,
    output logic        pkt_err,
    output logic [15:0] pkt_sent,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR_RD    = 3'd1;
    localparam logic [2:0] S_HDR_OUT   = 3'd2;
    localparam logic [2:0] S_BODY_WAIT = 3'd3;
    localparam logic [2:0] S_BODY_RD   = 3'd4;
    localparam logic [2:0] S_BODY_OUT  = 3'd5;
    localparam logic [2:0] S_GAP       = 3'd6;

    localparam int TW = (HINT_TIMEOUT > 1) ? $clog2(HINT_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(HINT_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]    LEN_LIM  = 8'(LEN_MAX);

    logic [2:0]    state;
    logic [7:0]    nwords;
    logic [7:0]    remaining;
    logic [TW-1:0] tmr;
    logic [GW-1:0] gap_cnt;
    logic          hint_ok;
    logic          timeout;
    logic          hdr_bad;
    logic [8:0]    len_p1;

    // A grant coincident with our own read request belongs to no request of ours.
    assign hint_ok = fifo_hint && !fifo_read;
    assign timeout = (tmr == TMR_LAST);
    assign hdr_bad = (fifo_data[7:0] == 8'd0) || (fifo_data[7:0] > LEN_LIM);
    assign len_p1  = {1'b0, fifo_data[7:0]} + 9'd1;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            fifo_read <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_first <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_word  <= 16'd0;
            pkt_sent  <= 16'd0;
            nwords    <= 8'd0;
            remaining <= 8'd0;
            tmr       <= '0;
            gap_cnt   <= '0;
        end else begin
            fifo_read <= 1'b0;
            pkt_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_read <= 1'b1;
                        tmr       <= '0;
                        state     <= S_HDR_RD;
                    end
                end
                S_HDR_RD: begin
                    if (hint_ok) begin
                        if (hdr_bad) begin
                            pkt_err <= 1'b1;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            pkt_word  <= fifo_data;
                            nwords    <= len_p1[8:1];
                            pkt_valid <= 1'b1;
                            pkt_first <= 1'b1;
                            state     <= S_HDR_OUT;
                        end
                    end else if (timeout) begin
                        pkt_err <= 1'b1;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                S_HDR_OUT: begin
                    if (pkt_ready) begin
                        pkt_valid <= 1'b0;
                        pkt_first <= 1'b0;
                        state     <= S_BODY_WAIT;
                    end
                end
                S_BODY_WAIT: begin
                    if (fifo_count >= {10'd0, nwords}) begin
                        fifo_read <= 1'b1;
                        remaining <= nwords;
                        tmr       <= '0;
                        state     <= S_BODY_RD;
                    end
                end
                S_BODY_RD: begin
                    if (hint_ok) begin
                        pkt_word  <= fifo_data;
                        remaining <= remaining - 8'd1;
                        pkt_valid <= 1'b1;
                        pkt_last  <= (remaining == 8'd1);
                        state     <= S_BODY_OUT;
                    end else if (timeout) begin
                        pkt_err <= 1'b1;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                S_BODY_OUT: begin
                    if (pkt_ready) begin
                        pkt_valid <= 1'b0;
                        pkt_last  <= 1'b0;
                        if (remaining == 8'd0) begin
                            pkt_sent <= pkt_sent + 16'd1;
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end else begin
                            fifo_read <= 1'b1;
                            tmr       <= '0;
                            state     <= S_BODY_RD;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pkt_gate.sv
// Randomized scoreboard bench for tx_pkt_gate with an SRAM grant responder and a radio-side monitor.
`timescale 1ns/100ps
module tb_tx_pkt_gate;

    localparam int LEN_MAX      = 200;
    localparam int GAP_CYCLES   = 8;
    localparam int HINT_TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [17:0] fifo_count;
    logic        fifo_read;
    logic        fifo_hint;
    logic [15:0] fifo_data;
    logic [15:0] pkt_word;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_first;
    logic        pkt_last;
    logic        pkt_err;
    logic [15:0] pkt_sent;
    logic        busy;

    tx_pkt_gate #(.LEN_MAX(LEN_MAX), .GAP_CYCLES(GAP_CYCLES), .HINT_TIMEOUT(HINT_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_read(fifo_read), .fifo_hint(fifo_hint), .fifo_data(fifo_data),
        .pkt_word(pkt_word), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_first(pkt_first), .pkt_last(pkt_last), .pkt_err(pkt_err),
        .pkt_sent(pkt_sent), .busy(busy)
    );

    typedef struct {
        logic [15:0] w;
        logic        f;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] mem[$];
    int          avail = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 2;
    int          pend = 0;
    int          mode = 0;
    bit          withhold = 0;
    bit          sb_en = 1;
    int          model_sent = 0;
    int          model_err = 0;
    int          err_seen = 0;
    int          reads = 0;
    int          valids = 0;
    int          last_cyc = 0;
    bit          last_seen = 0;

    assign fifo_count = avail[17:0];
    assign fifo_empty = (avail == 0);

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM side: answer each read with a grant 'lat' cycles later.
    initial begin
        fifo_hint = 0;
        fifo_data = 0;
        forever begin
            @(posedge clk);
            #1;
            fifo_hint = 0;
            if (reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0 && mem.size() > 0) begin
                        fifo_hint = 1;
                        fifo_data = mem.pop_front();
                        avail--;
                    end
                end
                if (fifo_read && !withhold) pend = lat;
            end
        end
    end

    initial begin
        int phase = 0;
        pkt_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: pkt_ready = 1;
                1: pkt_ready = 1'($urandom_range(0, 1));
                2: pkt_ready = (phase % 4 == 0);
                default: pkt_ready = 0;
            endcase
            phase++;
        end
    end

    // Radio side monitor: pops expected beats on every transfer.
    initial begin
        logic        pv = 0, pr = 0, pf = 0, pl = 0, prst = 1;
        logic [15:0] pw = 0;
        beat_t       e;
        forever begin
            @(posedge clk);
            #2;
            if (pkt_err) err_seen++;
            if (fifo_read) begin
                reads++;
                check("read_while_valid", {31'd0, pkt_valid}, 32'd0);
            end
            if (pkt_valid) valids++;
            if (pv && !pr && !prst && !reset)
                check("hold_stable", {13'd0, pkt_valid, pkt_first, pkt_last, pkt_word},
                      {13'd0, 1'b1, pf, pl, pw});
            if (pkt_valid && pkt_ready && sb_en) begin
                check("beat_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("beat", {14'd0, pkt_first, pkt_last, pkt_word}, {14'd0, e.f, e.l, e.w});
                end
                if (pkt_last) begin
                    last_cyc  = cyc;
                    last_seen = 1;
                end
            end
            pv = pkt_valid; pr = pkt_ready; pf = pkt_first; pl = pkt_last; pw = pkt_word;
            prst = reset;
        end
    end

    task automatic send_pkt(input logic [7:0] len, input logic [7:0] tag, input bit vis);
        int n;
        logic [15:0] w;
        beat_t b;
        n = (len == 0 || len > LEN_MAX) ? 0 : (int'(len) + 1) / 2;
        mem.push_back({tag, len});
        if (n == 0) begin
            model_err++;
        end else begin
            b.w = {tag, len}; b.f = 1; b.l = 0;
            sb.push_back(b);
            model_sent++;
        end
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            mem.push_back(w);
            b.w = w; b.f = 0; b.l = (i == n - 1);
            sb.push_back(b);
        end
        if (vis) avail += n + 1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 4000; k++) begin
            @(posedge clk);
            #3;
            if (mem.size() == 0 && pend == 0 && !fifo_hint && !busy) break;
        end
        if (k == 4000) begin
            total++;
            bad++;
            $display("FAIL %s_idle_timeout: busy=%0b mem=%0d want idle", name, busy, mem.size());
        end
        check({name, "_sb_empty"}, sb.size(), 32'd0);
        check({name, "_sent"}, {16'd0, pkt_sent}, 32'(model_sent & 16'hFFFF));
        check({name, "_err"}, err_seen, model_err);
    endtask

    initial begin
        int r0, v0, e0, k, seen;
        reset = 1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", {31'd0, pkt_valid}, 32'd0);
        check("rst_read", {31'd0, fifo_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sent", {16'd0, pkt_sent}, 32'd0);
        reset = 0;

        // Header 0x0A05, three body words, gap timing.
        mode = 0; lat = 2; last_seen = 0;
        send_pkt(8'h05, 8'h0A, 1);
        for (k = 0; k < 500; k++) begin
            @(posedge clk);
            #3;
            if (last_seen && !busy) break;
        end
        check("gap_len", cyc - last_cyc, GAP_CYCLES + 1);
        wait_idle("basic");

        // Body not yet resident: must hold without reading.
        r0 = reads;
        send_pkt(8'd6, 8'h33, 0);
        avail = 2;
        repeat (30) @(posedge clk);
        #3;
        check("wait_reads", reads - r0, 32'd1);
        check("wait_busy", {31'd0, busy}, 32'd1);
        avail += 2;
        wait_idle("wait");
        check("wait_reads_total", reads - r0, 32'd4);

        // Bad lengths.
        r0 = reads; v0 = valids;
        send_pkt(8'd0, 8'h11, 1);
        wait_idle("len0");
        check("len0_reads", reads - r0, 32'd1);
        check("len0_valids", valids - v0, 32'd0);
        r0 = reads; v0 = valids;
        send_pkt(8'(LEN_MAX + 1), 8'h22, 1);
        wait_idle("lenmax1");
        check("lenmax1_reads", reads - r0, 32'd1);
        check("lenmax1_valids", valids - v0, 32'd0);

        // Stalled radio: 1 on, 3 off.
        mode = 2; lat = 1;
        send_pkt(8'd8, 8'h44, 1);
        wait_idle("stall");

        // Grant withheld on the body read.
        begin
            beat_t b;
            mode = 0; lat = 2;
            mem.push_back(16'h5504); mem.push_back(16'hAAAA); mem.push_back(16'hBBBB);
            b.w = 16'h5504; b.f = 1; b.l = 0;
            sb.push_back(b);
            model_err++;
            avail = 3;
            e0 = err_seen;
            for (k = 0; k < 200; k++) begin
                @(posedge clk);
                #3;
                if (sb.size() == 0) break;
            end
            withhold = 1;
            for (k = 0; k < 200; k++) begin
                @(posedge clk);
                #3;
                if (err_seen != e0) break;
            end
            check("timeout_err", err_seen - e0, 32'd1);
            mem.delete();
            avail = 0;
            withhold = 0;
            wait_idle("timeout");
        end

        // Randomized packets.
        mode = 1;
        for (int p = 0; p < 12; p++) begin
            lat = $urandom_range(1, 3);
            send_pkt(8'($urandom_range(0, LEN_MAX + 15)), 8'($urandom), 1);
            wait_idle("rand");
        end

        // Reset while the second body word is presented.
        mode = 0; lat = 1; sb_en = 0;
        mem.push_back(16'h6608);
        for (int i = 0; i < 4; i++) mem.push_back(16'($urandom));
        avail = 5;
        seen = 0;
        for (k = 0; k < 500; k++) begin
            @(posedge clk);
            #3;
            if (pkt_valid && !pkt_first) seen++;
            if (seen == 2) break;
        end
        check("rst_mid_reached", seen, 32'd2);
        reset = 1;
        @(posedge clk);
        #3;
        check("rstm_read", {31'd0, fifo_read}, 32'd0);
        check("rstm_valid", {31'd0, pkt_valid}, 32'd0);
        check("rstm_first", {31'd0, pkt_first}, 32'd0);
        check("rstm_last", {31'd0, pkt_last}, 32'd0);
        check("rstm_err", {31'd0, pkt_err}, 32'd0);
        check("rstm_word", {16'd0, pkt_word}, 32'd0);
        check("rstm_sent", {16'd0, pkt_sent}, 32'd0);
        check("rstm_busy", {31'd0, busy}, 32'd0);
        mem.delete();
        avail = 0;
        sb.delete();
        model_sent = 0;
        reset = 0;
        sb_en = 1;
        @(posedge clk);
        #3;
        send_pkt(8'd3, 8'h77, 1);
        wait_idle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_pkt_gate.md
# tx_pkt_gate

Packet-level gate between the SRAM FIFO_I read port (CPU→radio direction) and the radio transmit path. Reads a length header word from FIFO_I and validates it. Waits until the whole packet body is resident in SRAM, then streams header and body words to the radio controller over a valid/ready handshake. Enforces a minimum inter-packet gap, so the radio is never started on a partially written packet.

## Interface

Parameters:
- LEN_MAX, 255: largest legal payload length in bytes, range 1..255.
- GAP_CYCLES, 64: idle clocks enforced after every packet or error, minimum 1.
- HINT_TIMEOUT, 1024: clocks to wait for a SRAM grant before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO_I empty.
- fifo_count  in  18  FIFO_I occupancy in 16-bit words.
- fifo_read  out  1  one-cycle read request to the SRAM controller.
- fifo_hint  in  1  SRAM grant; fifo_data is valid in the cycle this is high.
- fifo_data  in  16  word read from FIFO_I.
- pkt_word  out  16  beat to the radio controller.
- pkt_valid  out  1  pkt_word is valid.
- pkt_ready  in  1  radio controller accepts the beat.
- pkt_first  out  1  current beat is the header.
- pkt_last  out  1  current beat is the final body word.
- pkt_err  out  1  one-cycle pulse on bad length or grant timeout.
- pkt_sent  out  16  count of completed packets; wraps at 0xFFFF.
- busy  out  1  high in any state other than IDLE.

## Operation

Header word format:
- [7:0] = len, payload length in bytes.
- [15:8] = channel/tag, passed through untouched.
- Body words: nwords = (len+1)>>1, 8-bit result, maximum 128.

States: IDLE, HDR_RD, HDR_OUT, BODY_WAIT, BODY_RD, BODY_OUT, GAP.

- IDLE:
  - If !fifo_empty, pulse fifo_read and go to HDR_RD.
- HDR_RD:
  - On fifo_hint, latch fifo_data into the header register.
  - If len==0 or len>LEN_MAX: pulse pkt_err, go to GAP. The header is consumed; the body is not flushed, and the CPU is responsible for resync.
  - Otherwise latch nwords and go to HDR_OUT.
- HDR_OUT:
  - Drive pkt_valid=1, pkt_first=1, pkt_word=header.
  - On pkt_ready, go to BODY_WAIT.
- BODY_WAIT:
  - Stay until fifo_count >= nwords; the comparison is zero-extended to 18 bits.
  - Then pulse fifo_read and go to BODY_RD.
- BODY_RD:
  - On fifo_hint, latch the word, decrement the remaining count, go to BODY_OUT.
- BODY_OUT:
  - Drive pkt_valid=1; pkt_last=1 when remaining==0.
  - On pkt_ready with remaining==0: increment pkt_sent, go to GAP.
  - On pkt_ready otherwise: pulse fifo_read, go to BODY_RD.
- GAP:
  - Count GAP_CYCLES clocks, then return to IDLE.
- Grant timeout:
  - In HDR_RD or BODY_RD, HINT_TIMEOUT clocks without fifo_hint pulse pkt_err and go to GAP. pkt_sent is not incremented.
- Only one fifo_read is outstanding at a time. No read is issued while a beat is waiting for pkt_ready.
- pkt_word, pkt_first and pkt_last hold stable while pkt_valid=1 and pkt_ready=0.

## Timing

- Reset values: fifo_read=0, pkt_valid=0, pkt_first=0, pkt_last=0, pkt_err=0, pkt_word=0, pkt_sent=0, busy=0; state IDLE.
- Reset mid-packet: all of the above are restored in the next cycle. Words already read are lost; SRAM pointers are not touched.
- fifo_read is registered and asserts in the cycle after the state decision.
- fifo_hint is expected at least 1 clock after fifo_read. A hint in the same cycle as fifo_read is ignored.
- pkt_valid rises in the clock after fifo_hint is captured. A beat transfers on any clock edge with pkt_valid && pkt_ready.
- Minimum cost of a 1-word body with pkt_ready held high: 1 (IDLE) + 1 + hint latency (header) + 1 (HDR_OUT) + 1 (BODY_WAIT) + 1 + hint latency (body) + 1 (BODY_OUT), then GAP_CYCLES.
- Simultaneous fifo_empty deassert during GAP: ignored until IDLE.
- fifo_count decreasing below nwords in BODY_WAIT cannot happen (single reader). If fifo_count is below nwords, the block keeps waiting.
- pkt_sent increments on the transfer of the last beat, not on header transfer.

## Test plan

- Header 0x0A05 followed by 3 body words, pkt_ready held high, hint latency 2 → beats 0x0A05 (first), w0, w1, w2 (last); pkt_sent=1; busy low exactly GAP_CYCLES+1 clocks after the last beat.
- Header with len=6 while fifo_count=1 → holds in BODY_WAIT with no fifo_read; raising count to 3 issues exactly 3 reads and 3 body beats.
- Header with len=0, then a separate test with len=LEN_MAX+1 (LEN_MAX=200) → single pkt_err pulse, no pkt_valid, one fifo_read total, return to IDLE after the gap.
- pkt_ready toggled 1 cycle on, 3 cycles off across a 4-word body → pkt_word stable while stalled; no fifo_read while pkt_valid is pending; order preserved.
- Withhold fifo_hint for HINT_TIMEOUT clocks in BODY_RD → pkt_err pulse, pkt_sent unchanged, GAP then IDLE.
- Assert reset during BODY_OUT of the 2nd word → next cycle all outputs zero and state IDLE; the following valid packet streams correctly and pkt_sent reads 1.
